mul_shift_add: RTL and testbench
================================

Name: mul_shift_add

Overview:
- Sequential shift-add multiplier-accumulator, the inverse of the team's nonrestoring divider.
- Computes p = q*b + r, where q is the 32-bit quotient, b the 16-bit divisor and r the 16-bit remainder, so divider results can be recombined into the original dividend.
- Processes one multiplier bit per cycle over 16 cycles, with the same start/busy/ready handshake as the divider.
- Sits in the arithmetic datapath next to the divider and is used for remainder checking and for general 32x16 multiply.

Parameters:
- none; widths are fixed at q=32, b=16, r=16, p=48.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  asynchronous active-high reset.
- q  input  32  multiplicand, unsigned; sampled only when start=1.
- b  input  16  multiplier, unsigned; sampled only when start=1.
- r  input  16  addend, unsigned; sampled only when start=1.
- start  input  1  begin a new operation; 1-cycle pulse or level.
- p  output  48  product-plus-addend; valid while ready=1.
- ovf  output  1  high when p[47:32] != 0, i.e. the result does not fit 32 bits; combinational from p.
- busy  output  1  operation in progress.
- ready  output  1  result valid; held high until the next start.
- count  output  4  iteration counter, 0..15.

Behaviour:
- Reset (clr=1, asynchronous, overrides everything):
  - busy=0, ready=0, count=0, p=0, and all internal registers cleared.
  - Reset mid-operation aborts it; no result is produced.
  - After release, the block idles until start.
- Internal state:
  - acc[47:0], which drives p directly.
  - mcand[47:0], the multiplicand, shifted left each iteration.
  - mplier[15:0], the multiplier, shifted right each iteration.
  - count[3:0].
- Start edge (start=1), highest priority, accepted even while busy:
  - acc <= {32'b0, r}; mcand <= {16'b0, q}; mplier <= b.
  - count <= 0; busy <= 1; ready <= 0.
  - Start while busy discards the current operation and restarts with the new operands.
- Iteration edge (start=0, busy=1):
  - if mplier[0], acc <= acc + mcand, computed as a 48-bit add with the carry out discarded.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1, wrapping 15 -> 0.
  - when count==15 on this edge: busy <= 0, ready <= 1.
- Latency:
  - Start edge at cycle 0; ready rises at the 16th following edge, i.e. 16 cycles after start.
  - count reads 0 when ready rises.
- Idle (start=0, busy=0): all registers hold; p and ready are stable.
- Width rules:
  - The maximum result is (2^32-1)(2^16-1)+(2^16-1) = 0xFFFF_0000_0000, which is below 2^48.
  - No intermediate overflow is possible; the 48-bit accumulator is exact.
- p during busy holds partial sums and is undefined to consumers; only sample p when ready=1.
- b=0 is a legal operand: still 16 cycles, result p=r.
- There is no early termination; latency is fixed regardless of operand values.

Test Plan:
- After reset, check idle state:
  - Stimulus: assert clr mid-run, then release, with no start.
  - Required: busy=0, ready=0, count=0, p=0. Apply start afterwards and confirm normal operation resumes.
- Basic multiply-add:
  - Stimulus: q=0x0000_1234, b=0x0056, r=0x0007, one start pulse.
  - Required: ready rises exactly 16 cycles after the start edge; busy is high for cycles 1..16; p=0x0000_0006_1D7F; ovf=0; count=0.
- Maximum operands:
  - Stimulus: q=0xFFFF_FFFF, b=0xFFFF, r=0xFFFF.
  - Required: p=0xFFFF_0000_0000, ovf=1, no lost carry.
- Divider round-trip:
  - Stimulus: q=142857, b=7, r=1.
  - Required: p=1000000 (0x0F4240), ovf=0.
  - Also sweep random (a,b) through the divider model and check p==a on every pair.
- Zero multiplier and ready hold:
  - Stimulus: q=0xDEAD_BEEF, b=0, r=0x00AB.
  - Required: p=0x00AB after 16 cycles; ready and p stay stable for 10 idle cycles.
- Restart mid-operation:
  - Stimulus: start with q=5, b=3, r=0; at cycle 7 apply start with q=10, b=10, r=1.
  - Required: the first operation is abandoned; ready rises 16 cycles after the second start; p=101; ready stays 0 in between.

Source files
------------

// File: rtl/mul_shift_add_if.sv
//------------------------------------------------------------------------------
// Module  : mul_shift_add_if
// Brief   : Operand/result bundle for the 32x16 shift-add multiply-accumulate.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul_shift_add_if;
    logic [31:0] q;
    logic [15:0] b;
    logic [15:0] r;
    logic        start;
    logic [47:0] p;
    logic        ovf;
    logic        busy;
    logic        ready;
    logic [3:0]  count;

    modport master (
        output q, b, r, start,
        input  p, ovf, busy, ready, count
    );

    modport slave (
        input  q, b, r, start,
        output p, ovf, busy, ready, count
    );
endinterface

`default_nettype wire

// File: rtl/mul_shift_add.sv
//------------------------------------------------------------------------------
// Module  : mul_shift_add
// Brief   : Sequential p = q*b + r, one multiplier bit per cycle, 16 cycles.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_shift_add (
    input  wire            clk,
    input  wire            clr,
    mul_shift_add_if.slave bus
);

    localparam logic [3:0] C_LAST_ITER = 4'd15;

    logic [47:0] acc_q,    acc_d;
    logic [47:0] mcand_q,  mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  count_q,  count_d;
    logic        busy_q,   busy_d;
    logic        ready_q,  ready_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        busy_d   = busy_q;
        ready_d  = ready_q;

        // A new start always wins, even over an operation in flight.
        if (bus.start) begin
            acc_d    = {32'b0, bus.r};
            mcand_d  = {16'b0, bus.q};
            mplier_d = bus.b;
            count_d  = 4'd0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[46:0], 1'b0};
            mplier_d = {1'b0, mplier_q[15:1]};
            count_d  = count_q + 4'd1;
            if (count_q == C_LAST_ITER) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.p     = acc_q;
    assign bus.ovf   = |acc_q[47:32];
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_shift_add.sv
//------------------------------------------------------------------------------
// Module  : tb_mul_shift_add
// Brief   : Self-checking bench: directed vector table, corner sequences,
//           random multiply-add and divider round-trip against a model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_shift_add;

    logic clk;
    logic clr;
    mul_shift_add_if bus ();

    mul_shift_add dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] q;
        logic [15:0] b;
        logic [15:0] r;
        logic [47:0] exp_p;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [47:0] ref_mac(input logic [31:0] q,
                                            input logic [15:0] b,
                                            input logic [15:0] r);
        return 48'(q) * 48'(b) + 48'(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive operands and a one-cycle start; returns #1 after the start edge.
    task automatic start_op(input logic [31:0] q, input logic [15:0] b,
                            input logic [15:0] r);
        bus.q     = q;
        bus.b     = b;
        bus.r     = r;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait for ready, checking latency, busy shape and the result.
    task automatic wait_result(input string name, input logic [47:0] exp_p,
                               input logic exp_ovf);
        int lat;
        logic bad;
        lat = 0;
        bad = 1'b0;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) bad = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.ready === 1'b1) break;
            if (bus.busy !== 1'b1) bad = 1'b1;
        end
        check({name, " latency"}, 64'(lat), 64'd16);
        check({name, " busy/ready shape"}, 64'(bad), 64'd0);
        check({name, " p"}, 64'(bus.p), 64'(exp_p));
        check({name, " ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        check({name, " busy end"}, 64'(bus.busy), 64'd0);
        check({name, " count end"}, 64'(bus.count), 64'd0);
    endtask

    initial begin
        logic [31:0] rq, ra;
        logic [15:0] rb, rr;
        logic [47:0] held_p;

        vecs[0] = '{32'h0000_1234, 16'h0056, 16'h0007, 48'h0000_0006_1D7F, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000, 1'b1};
        vecs[2] = '{32'd142857,    16'd7,    16'd1,    48'h0000_000F_4240, 1'b0};
        vecs[3] = '{32'hDEAD_BEEF, 16'h0000, 16'h00AB, 48'h0000_0000_00AB, 1'b0};
        vecs[4] = '{32'h0000_0001, 16'h8000, 16'h0000, 48'h0000_0000_8000, 1'b0};

        bus.q = '0; bus.b = '0; bus.r = '0; bus.start = 1'b0;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check("reset busy",  64'(bus.busy),  64'd0);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset p",     64'(bus.p),     64'd0);

        // Reset in the middle of an operation aborts it.
        start_op(32'h1234_5678, 16'hABCD, 16'h1111);
        repeat (5) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        check("mid clr busy",  64'(bus.busy),  64'd0);
        check("mid clr count", 64'(bus.count), 64'd0);
        check("mid clr p",     64'(bus.p),     64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post clr idle busy",  64'(bus.busy),  64'd0);
        check("post clr idle ready", 64'(bus.ready), 64'd0);
        check("post clr idle count", 64'(bus.count), 64'd0);
        check("post clr idle p",     64'(bus.p),     64'd0);

        for (int i = 0; i < 5; i++) begin
            start_op(vecs[i].q, vecs[i].b, vecs[i].r);
            wait_result($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_ovf);
        end

        // Ready and p hold through idle cycles.
        start_op(32'hDEAD_BEEF, 16'h0000, 16'h00AB);
        wait_result("zero mult", 48'h00AB, 1'b0);
        held_p = bus.p;
        begin
            logic unstable;
            unstable = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (bus.ready !== 1'b1 || bus.p !== 48'h00AB) unstable = 1'b1;
            end
            check("ready/p hold", 64'(unstable), 64'd0);
            check("held p", 64'(bus.p), 64'(held_p));
        end

        // Restart 7 cycles into an operation.
        start_op(32'd5, 16'd3, 16'd0);
        begin
            logic early;
            early = 1'b0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (bus.ready !== 1'b0) early = 1'b1;
            end
            check("restart no early ready", 64'(early), 64'd0);
        end
        start_op(32'd10, 16'd10, 16'd1);
        wait_result("restart", 48'd101, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rq = $urandom;
            rb = 16'($urandom);
            rr = 16'($urandom);
            start_op(rq, rb, rr);
            wait_result($sformatf("rand%0d", i), ref_mac(rq, rb, rr),
                        ref_mac(rq, rb, rr) > 48'h0000_FFFF_FFFF);
        end

        // Recombine divider outputs into the original dividend.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(65535, 1));
            start_op(ra / 32'(rb), rb, 16'(ra % 32'(rb)));
            wait_result($sformatf("divrt%0d", i), 48'(ra), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
